// File: rtl/ysyx_22040088_pkg.sv
// ysyx_22040088_pkg: shared types and constants for the divw/remw divider
// Contents: FSM state encoding, default operand width, special-case result constants.
package ysyx_22040088_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/ysyx_22040088_div_step.sv
// ysyx_22040088_div_step: one combinational restoring-division iteration
// Ports:
//   rem      in   WIDTH+1  current partial remainder (always < divisor, so MSB is 0)
//   dvd_bit  in   1        next dividend bit shifted into the remainder
//   dvs      in   WIDTH    divisor magnitude
//   rem_next out  WIDTH+1  updated partial remainder
//   q_bit    out  1        quotient bit produced by this iteration
module ysyx_22040088_div_step import ysyx_22040088_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] shifted, diff;
    logic unused_msb;
    assign unused_msb = rem[WIDTH];
    always_comb begin
        shifted = {rem[WIDTH-1:0], dvd_bit};
        diff = shifted - {1'b0, dvs};
        // A set MSB means the subtraction borrowed: keep the shifted value.
        q_bit = ~diff[WIDTH];
        rem_next = q_bit ? diff : shifted;
    end
endmodule

// File: rtl/ysyx_22040088_divider.sv
// ysyx_22040088_divider: multi-cycle 32-bit divider for divw/remw (optionally divuw/remuw)
// Ports:
//   clk, rst (sync, active-high), flush (abort in-flight op, wins over in_valid)
//   in_valid/in_ready  launch handshake, in_ready high only in IDLE
//   is_rem             1 = remainder, 0 = quotient
//   is_signed          signed select; honoured only when YSYX_22040088_DIVU_EN is defined
//   src1, src2         64-bit operands, only the low WIDTH bits are used
//   out_valid          one-cycle result pulse
//   result             registered, sign-extended quotient or remainder
// Macro: YSYX_22040088_DIVU_EN enables the unsigned path; otherwise every op is signed.
module ysyx_22040088_divider import ysyx_22040088_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        is_rem,
    input  logic        is_signed,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    output logic        in_ready,
    output logic        out_valid,
    output logic [63:0] result
);
    localparam int CW = $clog2(WIDTH);
    state_t state;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] rem, rem_next;
    logic [WIDTH-1:0] a, b, abs_a, abs_b, dvd, dvs;
    logic [WIDTH-1:0] q_raw, r_raw, q_fin, r_fin, res_fin, spec_res;
    logic s1, s2, div_zero, ovf, q_bit, neg_q, neg_r, rem_op, unused;

    assign a = src1[WIDTH-1:0];
    assign b = src2[WIDTH-1:0];
`ifdef YSYX_22040088_DIVU_EN
    assign s1 = is_signed & a[WIDTH-1];
    assign s2 = is_signed & b[WIDTH-1];
    assign unused = ^{src1[63:WIDTH], src2[63:WIDTH]};
`else
    assign s1 = a[WIDTH-1];
    assign s2 = b[WIDTH-1];
    assign unused = ^{src1[63:WIDTH], src2[63:WIDTH], is_signed};
`endif

    ysyx_22040088_div_step #(.WIDTH(WIDTH)) u_step (
        .rem(rem),
        .dvd_bit(dvd[WIDTH-1]),
        .dvs(dvs),
        .rem_next(rem_next),
        .q_bit(q_bit)
    );

    always_comb begin
        abs_a = s1 ? -a : a;
        abs_b = s2 ? -b : b;
        div_zero = b == '0;
        // Both signs set only in signed mode, so this is inherently signed-only.
        ovf = s1 & s2 & (a == INT_MIN) & (b == DIV_ZERO_Q);
        spec_res = div_zero ? (is_rem ? a : DIV_ZERO_Q) : (is_rem ? '0 : INT_MIN);
        // dvd doubles as the quotient shift register; fold in the last bit here.
        q_raw = {dvd[WIDTH-2:0], q_bit};
        r_raw = rem_next[WIDTH-1:0];
        q_fin = neg_q ? -q_raw : q_raw;
        r_fin = neg_r ? -r_raw : r_raw;
        res_fin = rem_op ? r_fin : q_fin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            result <= '0;
            cnt <= '0;
        end else if (flush) begin
            state <= IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    rem_op <= is_rem;
                    neg_q <= s1 ^ s2;
                    neg_r <= s1;
                    in_ready <= 1'b0;
                    if (div_zero || ovf) begin
                        state <= DONE;
                        out_valid <= 1'b1;
                        result <= {{(64-WIDTH){spec_res[WIDTH-1]}}, spec_res};
                    end else begin
                        state <= CALC;
                        cnt <= CW'(WIDTH - 1);
                        rem <= '0;
                        dvd <= abs_a;
                        dvs <= abs_b;
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    dvd <= q_raw;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= DONE;
                        out_valid <= 1'b1;
                        result <= {{(64-WIDTH){res_fin[WIDTH-1]}}, res_fin};
                    end
                end
                DONE: begin
                    state <= IDLE;
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22040088_divider.sv
// tb_ysyx_22040088_divider: directed self-checking bench for the divw/remw divider
module tb_ysyx_22040088_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic is_rem = 1'b0;
    logic is_signed = 1'b1;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic in_ready, out_valid;
    logic [63:0] result;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22040088_divider dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .is_rem(is_rem), .is_signed(is_signed), .src1(src1), .src2(src2),
        .in_ready(in_ready), .out_valid(out_valid), .result(result)
    );

    // Launch one operation and return the result plus the cycle count from accept to out_valid.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic r, input logic s,
                         output logic [63:0] res, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        src1 = a; src2 = b; is_rem = r; is_signed = s; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        res = result;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    endtask

    task automatic test_divide;
        logic [63:0] res;
        int lat;
        do_op(64'd100, 64'd7, 1'b0, 1'b1, res, lat);
        checks++; if (res !== 64'd14) begin errors++; $display("FAIL div_100_7: got %h expected %h", res, 64'd14); end
        checks++; if (lat != 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", lat); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pulse_width: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_done: got %b expected 1", in_ready); end
        checks++; if (result !== 64'd14) begin errors++; $display("FAIL result_hold: got %h expected %h", result, 64'd14); end
        do_op(64'd100, 64'd7, 1'b1, 1'b1, res, lat);
        checks++; if (res !== 64'd2) begin errors++; $display("FAIL rem_100_7: got %h expected %h", res, 64'd2); end
    endtask

    task automatic test_negative;
        logic [63:0] res;
        int lat;
        do_op(64'h0000_0000_FFFF_FF9C, 64'd7, 1'b0, 1'b1, res, lat);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFF2) begin errors++; $display("FAIL div_m100_7: got %h expected %h", res, 64'hFFFF_FFFF_FFFF_FFF2); end
        do_op(64'h0000_0000_FFFF_FF9C, 64'd7, 1'b1, 1'b1, res, lat);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL rem_m100_7: got %h expected %h", res, 64'hFFFF_FFFF_FFFF_FFFE); end
        do_op(64'd7, 64'h0000_0000_FFFF_FFFE, 1'b0, 1'b1, res, lat);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_7_m2: got %h expected %h", res, 64'hFFFF_FFFF_FFFF_FFFD); end
        do_op(64'd7, 64'h0000_0000_FFFF_FFFE, 1'b1, 1'b1, res, lat);
        checks++; if (res !== 64'd1) begin errors++; $display("FAIL rem_7_m2: got %h expected %h", res, 64'd1); end
    endtask

    task automatic test_div_zero;
        logic [63:0] res;
        int lat;
        do_op(64'hDEAD_0000_0000_0005, 64'd0, 1'b0, 1'b1, res, lat);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divz_quot: got %h expected %h", res, 64'hFFFF_FFFF_FFFF_FFFF); end
        checks++; if (lat != 1) begin errors++; $display("FAIL divz_latency: got %0d expected 1", lat); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL divz_ready: got %b expected 1", in_ready); end
        do_op(64'hDEAD_0000_0000_0005, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1, res, lat);
        checks++; if (res !== 64'd5) begin errors++; $display("FAIL divz_rem: got %h expected %h", res, 64'd5); end
    endtask

    task automatic test_overflow;
        logic [63:0] res;
        int lat;
        do_op(64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 1'b1, res, lat);
        checks++; if (res !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL ovf_quot: got %h expected %h", res, 64'hFFFF_FFFF_8000_0000); end
        checks++; if (lat != 1) begin errors++; $display("FAIL ovf_latency: got %0d expected 1", lat); end
        do_op(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, res, lat);
        checks++; if (res !== 64'd0) begin errors++; $display("FAIL ovf_rem: got %h expected 0", res); end
    endtask

    task automatic test_busy_ignore;
        int lat;
        @(negedge clk);
        src1 = 64'd50; src2 = 64'd5; is_rem = 1'b0; is_signed = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 src1 = 64'd81; src2 = 64'd0;
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        lat = 10;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (result !== 64'd10) begin errors++; $display("FAIL busy_result: got %h expected %h", result, 64'd10); end
        checks++; if (lat != 33) begin errors++; $display("FAIL busy_latency: got %0d expected 33", lat); end
    endtask

    task automatic test_flush;
        logic [63:0] res;
        int lat;
        int seen;
        @(negedge clk);
        src1 = 64'd1000; src2 = 64'd3; is_rem = 1'b0; is_signed = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
        seen = 0;
        repeat (40) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_valid: got %0d pulses expected 0", seen); end
        do_op(64'd81, 64'd9, 1'b0, 1'b1, res, lat);
        checks++; if (res !== 64'd9) begin errors++; $display("FAIL after_flush: got %h expected %h", res, 64'd9); end
    endtask

    task automatic test_flush_accept;
        int seen;
        @(negedge clk);
        src1 = 64'd3; src2 = 64'd0; is_rem = 1'b0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_wins: got %0d busy cycles expected 0", seen); end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        src1 = 64'd100; src2 = 64'd7; is_rem = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_valid: got %0d pulses expected 0", seen); end
        checks++; if (result !== 64'd0) begin errors++; $display("FAIL rst_mid_result: got %h expected 0", result); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] r1, r2;
        int l1, l2;
        do_op(64'd9, 64'd0, 1'b1, 1'b1, r1, l1);
        do_op(64'd12, 64'd0, 1'b1, 1'b1, r2, l2);
        checks++; if (r1 !== 64'd9 || r2 !== 64'd12) begin errors++; $display("FAIL b2b_special: got %h/%h expected 9/c", r1, r2); end
    endtask

    task automatic test_unsigned;
        logic [63:0] res;
        int lat;
        do_op(64'hFFFF_FFFF, 64'd2, 1'b0, 1'b0, res, lat);
`ifdef YSYX_22040088_DIVU_EN
        checks++; if (res !== 64'h0000_0000_7FFF_FFFF) begin errors++; $display("FAIL divu_ffff_2: got %h expected %h", res, 64'h0000_0000_7FFF_FFFF); end
`else
        checks++; if (res !== 64'd0) begin errors++; $display("FAIL forced_signed_m1_2: got %h expected 0", res); end
`endif
        do_op(64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 1'b0, res, lat);
`ifdef YSYX_22040088_DIVU_EN
        checks++; if (res !== 64'd0 || lat != 33) begin errors++; $display("FAIL divu_no_ovf: got %h lat %0d expected 0 lat 33", res, lat); end
`else
        checks++; if (res !== 64'hFFFF_FFFF_8000_0000 || lat != 1) begin errors++; $display("FAIL forced_signed_ovf: got %h lat %0d expected ffffffff80000000 lat 1", res, lat); end
`endif
    endtask

    initial begin
        test_reset;
        test_divide;
        test_negative;
        test_div_zero;
        test_overflow;
        test_busy_ignore;
        test_flush;
        test_flush_accept;
        test_reset_mid;
        test_back_to_back;
        test_unsigned;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
